token_sched: RTL and testbench
==============================

# token_sched

Round-robin scheduler that shares one serial token-doubling output line between N_CH serial token sources. Each channel accumulates incoming '1' tokens in a saturating pending counter. The scheduler grants one channel at a time and replays that channel's pending tokens on `b`, two high cycles per token. It sits between several token producers and the single downstream serial consumer, and keeps a sticky per-channel overflow flag.

## Interface

**Parameters**
- `N_CH`, default 4: number of requester channels, ≥2.
- `MAX_PEND`, default 200: maximum pending tokens per channel.

**Ports**
- `clk` input, 1: clock. All state updates on posedge.
- `rst` input, 1: reset, synchronous, active-high.
- `a` input, N_CH: per-channel serial token lines; `a[i]`=1 in a cycle is one token.
- `en` input, 1: scheduler enable. Low blocks new grants only.
- `b` output, 1: shared doubled serial token output.
- `busy` output, 1: high while a burst is being emitted or gapped.
- `ch_id` output, $clog2(N_CH): channel currently or last granted.
- `overflow` output, N_CH: sticky per-channel overflow.

## Operation

**Widths**
- `PEND_W` = $clog2(MAX_PEND+1).
- `BURST_W` = PEND_W+1.

**Pending counters**
- Each cycle with `a[i]`=1 and `pend[i]` < MAX_PEND: `pend[i]` increments.
- `a[i]`=1 with `pend[i]` == MAX_PEND: token dropped, `overflow[i]` set. It stays set until `rst`.
- Counters keep accumulating during any other channel's burst.

**FSM states: IDLE, EMIT, GAP**
- IDLE: if `en`=1 and any `pend` ≠ 0, grant the selected channel `g`:
  - `burst` <= 2·`pend[g]`; `pend[g]` <= `a[g]` (the token arriving in the grant cycle is kept, not lost).
  - `ch_id` <= `g`; last-grant pointer <= `g`; state <= EMIT.
- EMIT: `burst` decrements each cycle. When `burst` == 1, state <= GAP.
- GAP: one cycle, then state <= IDLE.

**Outputs**
- `b` = (state == EMIT). Registered-state decode, no combinational path from `a`.
- `busy` = (state ≠ IDLE).

**Arbitration (default)**
- Round-robin: search starts at last-grant+1, wraps modulo N_CH, and picks the first channel with `pend` ≠ 0.
- The last-grant pointer resets to N_CH-1, so channel 0 wins first.

**Boundary conditions**
- `en` falling mid-burst: the current burst completes; no new grant until `en`=1.
- `rst` mid-burst: next cycle `b`=0, `busy`=0, all `pend`=0, `overflow`=0, state IDLE.
- A channel at MAX_PEND granted: burst = 2·MAX_PEND cycles. `BURST_W` must hold 2·MAX_PEND.

## Timing

- Reset values: `b`=0, `busy`=0, `ch_id`=0, `overflow`=0, all `pend`=0, state IDLE.
- Latency, scheduler idle with `en`=1: token on `a[i]` in cycle t → `pend[i]`=1 in cycle t+1 → grant at end of t+1 → `b`=1 in cycles t+2 and t+3 → `b`=0 in t+4 (GAP).
- Back-to-back bursts are separated by at least two low cycles on `b` (GAP plus IDLE).
- `ch_id` updates in the first EMIT cycle and holds through GAP and IDLE.

## Configuration

- `TOKEN_SCHED_FIXED_PRIO_EN` defined: fixed priority. The lowest-index channel with `pend` ≠ 0 always wins; the last-grant pointer is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

## Structure

- Package `token_sched_pkg` holds:
  - the state enum `token_sched_state_t` (IDLE, EMIT, GAP);
  - default constants `TOKEN_SCHED_N_CH`=4 and `TOKEN_SCHED_MAX_PEND`=200;
  - the width helper for `PEND_W`/`BURST_W`.
- One sub-module, `token_rr_arb`:
  - combinational arbiter taking the request vector (`pend` ≠ 0) and the last-grant pointer;
  - returns `valid` and grant index;
  - the `TOKEN_SCHED_FIXED_PRIO_EN` selection lives inside it.

## Test plan

- **Single token, channel 0:** after reset, `a`=0001 for one cycle → `b`=1 for exactly 2 cycles starting 2 cycles later, `ch_id`=0, then 1 low GAP cycle, `busy` drops.
- **Round-robin fairness:** `a`=1111 for 3 cycles → bursts of 6 high cycles each, served in order ch0, ch1, ch2, ch3, each burst followed by ≥2 low cycles. With `TOKEN_SCHED_FIXED_PRIO_EN`, re-loading ch0 during ch1's burst → ch0 served next.
- **Overflow:** `a[2]`=1 for 201 consecutive cycles with `en`=0 → `pend[2]`=200, `overflow[2]`=1. Set `en`=1 → 400-cycle burst. `overflow[2]` stays 1 until `rst`.
- **Token during grant:** `a[1]` high in the grant cycle of ch1 → current burst reflects the old count; `pend[1]`=1 remains and is served in a later 2-cycle burst.
- **Enable gating:** drop `en` mid-burst → burst finishes at full length; no further grants while `en`=0 despite `pend` ≠ 0.
- **Reset mid-burst:** `rst` high during EMIT → next cycle `b`=0, `busy`=0, `overflow`=0; subsequent tokens behave as after power-up.

Source files
------------

// File: rtl/token_sched_pkg.sv
// Shared types, default sizes and width helpers for the token_sched scheduler.
// Optional build macro: TOKEN_SCHED_FIXED_PRIO_EN (fixed-priority arbitration).
package token_sched_pkg;

  localparam int TOKEN_SCHED_N_CH     = 4;
  localparam int TOKEN_SCHED_MAX_PEND = 200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } token_sched_state_t;

  // Pending counter width: must hold 0..max_pend inclusive.
  function automatic int pend_width(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

  // Burst counter width: one extra bit because a burst is twice the pending count.
  function automatic int burst_width(input int max_pend);
    return pend_width(max_pend) + 1;
  endfunction

endpackage

// File: rtl/token_sched_arb.sv
// Combinational channel arbiter for token_sched: round-robin after the last grant,
// or lowest-index fixed priority when TOKEN_SCHED_FIXED_PRIO_EN is defined.
module token_rr_arb
  import token_sched_pkg::*;
#(
  parameter int  N_CH = TOKEN_SCHED_N_CH,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_last,
  output logic            o_valid,
  output logic [CH_W-1:0] o_gnt
);

  logic [CH_W-1:0] w_idx;

  // NOTE: every output gets a default first, so no path through the loops infers a latch.
  always_comb begin
    o_valid = 1'b0;
    o_gnt   = '0;
    w_idx   = '0;
`ifdef TOKEN_SCHED_FIXED_PRIO_EN
    // Scan high to low so the lowest requesting index is the last one written.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_gnt   = CH_W'(i);
      end
    end
`else
    // Scan from the farthest candidate (last grant itself) to the nearest (last+1),
    // so the winner is the first requester after the last grant, wrapping.
    for (int k = N_CH; k >= 1; k--) begin
      w_idx = CH_W'((int'(i_last) + k) % N_CH);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_gnt   = w_idx;
      end
    end
`endif
  end

endmodule

// File: rtl/token_sched.sv
// Shares one doubled serial token output between N_CH token sources with per-channel
// saturating pending counters. Build macro: TOKEN_SCHED_FIXED_PRIO_EN selects fixed priority.
module token_sched
  import token_sched_pkg::*;
#(
  parameter int  N_CH     = TOKEN_SCHED_N_CH,
  parameter int  MAX_PEND = TOKEN_SCHED_MAX_PEND,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] a,
  input  logic            en,
  output logic            b,
  output logic            busy,
  output logic [CH_W-1:0] ch_id,
  output logic [N_CH-1:0] overflow
);

  localparam int PEND_W  = pend_width(MAX_PEND);
  localparam int BURST_W = burst_width(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  token_sched_state_t r_state;
  logic [BURST_W-1:0] r_burst;
  logic [PEND_W-1:0]  r_pend [N_CH];
  logic [N_CH-1:0]    r_overflow;
  logic [CH_W-1:0]    r_last;
  logic [CH_W-1:0]    r_ch_id;
  logic               r_b;
  logic               r_busy;

  logic [N_CH-1:0]    w_req;
  logic               w_valid;
  logic [CH_W-1:0]    w_gnt;
  logic               w_grant;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_req[i] = (r_pend[i] != '0);
    end
  end

  token_rr_arb #(
    .N_CH (N_CH)
  ) u_arb (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_gnt   (w_gnt)
  );

  assign w_grant = (r_state == IDLE) && en && w_valid;

  // Pending counters keep accumulating regardless of which channel owns the output.
  // NOTE: the pending array is a few counters, not a RAM, so it is reset like any flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_pend[i] <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_grant && (w_gnt == CH_W'(i))) begin
          // The whole count moves into the burst; a token arriving now stays pending.
          r_pend[i] <= {{(PEND_W-1){1'b0}}, a[i]};
        end else if (a[i]) begin
          if (r_pend[i] < PEND_MAX) begin
            r_pend[i] <= r_pend[i] + PEND_W'(1);
          end else begin
            r_overflow[i] <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_burst <= '0;
      r_ch_id <= '0;
      r_last  <= CH_W'(N_CH - 1);
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_burst <= {r_pend[w_gnt], 1'b0};
            r_ch_id <= w_gnt;
            r_last  <= w_gnt;
            r_state <= EMIT;
            r_b     <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        EMIT: begin
          r_burst <= r_burst - BURST_W'(1);
          if (r_burst == BURST_W'(1)) begin
            r_state <= GAP;
            r_b     <= 1'b0;
          end
        end
        GAP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_b     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign b        = r_b;
  assign busy     = r_busy;
  assign ch_id    = r_ch_id;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_token_sched.sv
// Self-checking bench for token_sched: directed scenarios plus random traffic, all
// checked every cycle against a cycle-count reference model of the scheduling rules.
module tb_token_sched;

  localparam int N_CH     = 4;
  localparam int MAX_PEND = 200;
  localparam int CH_W     = $clog2(N_CH);

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N_CH-1:0] a;
  logic            b;
  logic            busy;
  logic [CH_W-1:0] ch_id;
  logic [N_CH-1:0] overflow;

  int n_total = 0;
  int n_bad   = 0;
  int hi_cnt  = 0;

  // Reference model: plain integers describing the observable behaviour.
  int m_pend [N_CH];
  bit m_ovf  [N_CH];
  int m_hi;    // remaining high cycles on b
  bit m_gap;   // in the single low cycle after a burst
  int m_ch;
  int m_last;

  token_sched #(
    .N_CH     (N_CH),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .en       (en),
    .b        (b),
    .busy     (busy),
    .ch_id    (ch_id),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_pend[i] = 0;
      m_ovf[i]  = 1'b0;
    end
    m_hi   = 0;
    m_gap  = 1'b0;
    m_ch   = 0;
    m_last = N_CH - 1;
  endfunction

  function automatic logic [N_CH-1:0] model_ovf();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs held during that cycle.
  task automatic model_step();
    int g;
    int idx;
    g = -1;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_hi == 0 && !m_gap && en) begin
`ifdef TOKEN_SCHED_FIXED_PRIO_EN
      for (int i = 0; i < N_CH; i++)
        if (g < 0 && m_pend[i] > 0) g = i;
`else
      for (int k = 1; k <= N_CH; k++) begin
        idx = (m_last + k) % N_CH;
        if (g < 0 && m_pend[idx] > 0) g = idx;
      end
`endif
    end
    if (m_hi > 0) begin
      m_hi--;
      if (m_hi == 0) m_gap = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (g >= 0) begin
      m_hi   = 2 * m_pend[g];
      m_ch   = g;
      m_last = g;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (i == g) m_pend[i] = a[i] ? 1 : 0;
      else if (a[i]) begin
        if (m_pend[i] < MAX_PEND) m_pend[i]++;
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  // One clock cycle: apply inputs, compare outputs mid-cycle, then advance the model.
  task automatic cycle(input logic [N_CH-1:0] a_v, input logic en_v, input logic rst_v);
    a   = a_v;
    en  = en_v;
    rst = rst_v;
    @(negedge clk);
    check("b",        32'(b),        32'(m_hi > 0));
    check("busy",     32'(busy),     32'((m_hi > 0) || m_gap));
    check("ch_id",    32'(ch_id),    32'(m_ch));
    check("overflow", 32'(overflow), 32'(model_ovf()));
    if (b === 1'b1) hi_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic en_v);
    for (int i = 0; i < n; i++) cycle('0, en_v, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // Single token on channel 0 right after reset.
    hi_cnt = 0;
    cycle(4'b0001, 1'b1, 1'b0);
    idle(8, 1'b1);
    check("single_len", hi_cnt, 2);

    // Round-robin fairness: three tokens per channel, released together.
    hi_cnt = 0;
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, 1'b0);
    idle(50, 1'b1);
    check("rr_total_len", hi_cnt, 24);

    // Token arriving in the grant cycle is kept and served later.
    hi_cnt = 0;
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);
    idle(12, 1'b1);
    check("grant_token_len", hi_cnt, 4);

    // Overflow on channel 2 while blocked, then one maximal burst.
    for (int i = 0; i < MAX_PEND + 1; i++) cycle(4'b0100, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("ovf2_set", 32'(overflow[2]), 1);
    hi_cnt = 0;
    idle(410, 1'b1);
    check("max_burst_len", hi_cnt, 2 * MAX_PEND);
    check("ovf2_sticky", 32'(overflow[2]), 1);

    // Enable dropped mid-burst: burst completes, nothing new until enable returns.
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    idle(30, 1'b0);
    check("en_gate_len", hi_cnt, 10);
    hi_cnt = 0;
    idle(20, 1'b1);
    check("en_resume_len", hi_cnt, 4);

    // Reset in the middle of a burst, then behave as after power-up.
    for (int i = 0; i < 3; i++) cycle(4'b1000, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf",  32'(overflow), 0);
    cycle(4'b1001, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("rst_first_ch", 32'(ch_id), 0);
    idle(10, 1'b1);

    // Random traffic with occasional enable drops and rare resets.
    for (int n = 0; n < 3000; n++) begin
      logic [N_CH-1:0] av;
      av = ($urandom_range(0, 2) == 0) ? N_CH'($urandom) : '0;
      cycle(av, ($urandom_range(0, 9) != 0), ($urandom_range(0, 699) == 0));
    end
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
